// File: rtl/mem_req_arbiter.sv
// Two-into-one SRAM-bus arbiter (data priority, inst starvation guard); zero-cycle address and data paths.
// Backpressure: mem_req held low while the response tag FIFO is full; a grant stays locked until mem_addr_ok.
module mem_req_arbiter #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [3:0]  inst_wstrb,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int SC_W  = $clog2(STARVE_LIMIT + 1);

    typedef enum logic {IDLE, LOCK} state_t;

    state_t             state_q, state_d;
    logic               lock_sel_q, lock_sel_d;
    logic [DEPTH-1:0]   fifo_q, fifo_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [SC_W-1:0]    starve_cnt_q, starve_cnt_d;

    logic full, starved, sel, sel_req, push, pop;

    always_comb begin
        full    = (count_q == CNT_W'(DEPTH));
        starved = inst_req && (starve_cnt_q == SC_W'(STARVE_LIMIT));

        // sel: 1 = data port, 0 = inst port; data fields are the idle default
        if (state_q == LOCK)
            sel = lock_sel_q;
        else if (data_req && !starved)
            sel = 1'b1;
        else if (inst_req)
            sel = 1'b0;
        else
            sel = 1'b1;

        sel_req    = sel ? data_req : inst_req;
        mem_req    = sel_req && !full && !reset;
        mem_wr     = sel ? data_wr    : inst_wr;
        mem_size   = sel ? data_size  : inst_size;
        mem_addr   = sel ? data_addr  : inst_addr;
        mem_wstrb  = sel ? data_wstrb : inst_wstrb;
        mem_wdata  = sel ? data_wdata : inst_wdata;

        push         = mem_req && mem_addr_ok;
        inst_addr_ok = push && !sel;
        data_addr_ok = push && sel;

        // a response with nothing outstanding is dropped without touching the FIFO
        pop          = mem_data_ok && (count_q != '0) && !reset;
        inst_data_ok = pop && !fifo_q[rd_ptr_q];
        data_data_ok = pop && fifo_q[rd_ptr_q];
        inst_rdata   = mem_rdata;
        data_rdata   = mem_rdata;

        state_d      = state_q;
        lock_sel_d   = lock_sel_q;
        fifo_d       = fifo_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q + CNT_W'(push) - CNT_W'(pop);
        starve_cnt_d = starve_cnt_q;

        if (push) begin
            fifo_d[wr_ptr_q] = sel;
            wr_ptr_d         = wr_ptr_q + PTR_W'(1);
            state_d          = IDLE;
            if (sel && inst_req) begin
                if (starve_cnt_q != SC_W'(STARVE_LIMIT))
                    starve_cnt_d = starve_cnt_q + SC_W'(1);
            end else begin
                starve_cnt_d = '0;
            end
        end else if (mem_req && state_q == IDLE) begin
            state_d    = LOCK;
            lock_sel_d = sel;
        end

        if (pop)
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            lock_sel_q   <= 1'b0;
            fifo_q       <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            starve_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            lock_sel_q   <= lock_sel_d;
            fifo_q       <= fifo_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end
endmodule
